// File: rtl/core_io_pkg.sv
// Shared definitions for the core byte I/O paths (transmit and receive).
package core_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic TXD_IDLE             = 1'b1;
  // Default bit period; the receive path uses the same constant.
  localparam int   DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/core_out_ser.sv
// UART 8N1 serializer: START/DATA/STOP framing with a down-counting baud
// counter. Pops a byte from the upstream buffer when idle or at the end of a
// stop bit, so consecutive frames run back-to-back with no idle gap.
// The idle output reports whether the serializer will be IDLE after the
// current edge, so the parent can register its busy flag without lag.
module core_out_ser
  import core_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       pop,
  output logic       txd,
  output logic       idle
);

  localparam logic [15:0] RELOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  sh, sh_nxt;
  logic        txd_nxt;
  logic        tick;

  assign tick = (cnt == 16'd0);

  // Next-state, next-bit and pop decision for the framing FSM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    txd_nxt   = txd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = TXD_IDLE;
        if (valid) begin
          pop       = 1'b1;
          sh_nxt    = data;
          txd_nxt   = 1'b0;
          cnt_nxt   = RELOAD;
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
          txd_nxt   = sh[0];
          cnt_nxt   = RELOAD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_nxt = RELOAD;
          sh_nxt  = sh >> 1;
          if (idx == LAST_BIT) begin
            state_nxt = STOP;
            txd_nxt   = TXD_IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
            txd_nxt = sh[1];
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (valid) begin
            pop       = 1'b1;
            sh_nxt    = data;
            txd_nxt   = 1'b0;
            cnt_nxt   = RELOAD;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle = (state_nxt == IDLE);

  // Control flops; reset aborts any frame and returns the line to idle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      txd   <= TXD_IDLE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      txd   <= txd_nxt;
    end
  end

  // Shift register holds data only, so it needs no reset.
  always_ff @(posedge CLK) begin
    sh <= sh_nxt;
  end

endmodule

// File: rtl/core_out_tx.sv
// Core byte output path: buffers OUT_WE bytes and sends them as UART 8N1.
// Build option CORE_OUT_FIFO_EN selects a circular FIFO of
// 2**FIFO_DEPTH_LOG2 bytes; without it a single holding register is used.
// OUT_FULL and TX_BUSY are registered and describe the state after each edge.
module core_out_tx
  import core_io_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       OUT_WE,
  input  logic [7:0] OUT_DATA,
  output logic       OUT_FULL,
  output logic       TX_BUSY,
  output logic       TXD
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      FIFO_DEPTH_LOG2 < 1 || FIFO_DEPTH_LOG2 > 16) begin : g_param_check
    $error("core_out_tx: parameter out of range");
  end

  logic       wr;
  logic       pop;
  logic       nonempty;
  logic       nonempty_nxt;
  logic       full_nxt;
  logic [7:0] head;
  logic       ser_idle;

  // A write is taken only when the registered full flag is clear; a pop in
  // the same cycle does not make room for it.
  assign wr = OUT_WE && !OUT_FULL;

`ifdef CORE_OUT_FIFO_EN
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]              count, count_nxt;

  // Occupancy after this edge; simultaneous write and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (wr && !pop)      count_nxt = count + CW'(1);
    else if (!wr && pop) count_nxt = count - CW'(1);
  end

  assign nonempty     = (count != '0);
  assign nonempty_nxt = (count_nxt != '0);
  assign full_nxt     = (count_nxt == CW'(DEPTH));
  assign head         = mem[rptr];

  // Pointers and occupancy; pointers wrap naturally modulo the depth.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + FIFO_DEPTH_LOG2'(1);
      if (pop) rptr <= rptr + FIFO_DEPTH_LOG2'(1);
      count <= count_nxt;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= OUT_DATA;
  end
`else
  logic [7:0] hold;
  logic       hold_vld;

  // Write and pop never coincide here: write needs an empty register and
  // pop needs a full one.
  always_comb begin
    nonempty_nxt = hold_vld;
    if (wr)       nonempty_nxt = 1'b1;
    else if (pop) nonempty_nxt = 1'b0;
  end

  assign nonempty = hold_vld;
  assign full_nxt = nonempty_nxt;
  assign head     = hold;

  // Valid bit of the holding register.
  always_ff @(posedge CLK) begin
    if (!RST_N) hold_vld <= 1'b0;
    else        hold_vld <= nonempty_nxt;
  end

  // Holding register data.
  always_ff @(posedge CLK) begin
    if (wr) hold <= OUT_DATA;
  end
`endif

  core_out_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .CLK  (CLK),
    .RST_N(RST_N),
    .valid(nonempty),
    .data (head),
    .pop  (pop),
    .txd  (TXD),
    .idle (ser_idle)
  );

  // Registered status flags computed from the post-edge buffer/FSM state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_FULL <= 1'b0;
      TX_BUSY  <= 1'b0;
    end else begin
      OUT_FULL <= full_nxt;
      TX_BUSY  <= nonempty_nxt || !ser_idle;
    end
  end

endmodule

// File: tb/tb_core_out_tx.sv
// Self-checking bench for core_out_tx (CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=4).
// A frame-level timeline model (byte queue + "serializer free at edge" time)
// predicts TXD, OUT_FULL and TX_BUSY after every edge; directed sequences add
// hand-derived checkpoints. Buffer capacity follows CORE_OUT_FIFO_EN.
module tb_core_out_tx;

  localparam int CPB   = 4;
  localparam int DL2   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef CORE_OUT_FIFO_EN
  localparam int CAP = 1 << DL2;
`else
  localparam int CAP = 1;
`endif

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b0;
  logic       OUT_WE   = 1'b0;
  logic [7:0] OUT_DATA = 8'h00;
  logic       OUT_FULL;
  logic       TX_BUSY;
  logic       TXD;

  core_out_tx #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG2(DL2)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .OUT_WE  (OUT_WE),
    .OUT_DATA(OUT_DATA),
    .OUT_FULL(OUT_FULL),
    .TX_BUSY (TX_BUSY),
    .TXD     (TXD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  byte unsigned q[$];
  int           t           = 0;
  int           busy_until  = 0;
  int           frame_start = -100;
  logic [7:0]   frame_byte  = 8'h00;
  logic         exp_txd, exp_full, exp_busy;

  typedef struct {
    int   off;
    logic txd;
    logic busy;
    logic full;
  } chk_t;
  chk_t tbl[15];

  function automatic logic frame_bit(input int off, input logic [7:0] b);
    int k;
    k = off / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic model_edge(input logic rst_n, input logic we, input logic [7:0] d);
    bit do_pop;
    bit do_wr;
    t++;
    if (!rst_n) begin
      q.delete();
      busy_until  = t;
      frame_start = t - FRAME;
    end else begin
      do_pop = (q.size() > 0) && (t >= busy_until);
      do_wr  = we && (q.size() < CAP);
      if (do_pop) begin
        frame_byte  = q.pop_front();
        frame_start = t;
        busy_until  = t + FRAME;
      end
      if (do_wr) q.push_back(d);
    end
    exp_full = (q.size() == CAP);
    exp_busy = (q.size() > 0) || (t < busy_until);
    if (t >= frame_start && t < frame_start + FRAME)
      exp_txd = frame_bit(t - frame_start, frame_byte);
    else
      exp_txd = 1'b1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, t, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic we, input logic [7:0] d);
    RST_N    = rst_n;
    OUT_WE   = we;
    OUT_DATA = d;
    @(posedge CLK);
    model_edge(rst_n, we, d);
    #1;
    check("model_txd", TXD, exp_txd);
    check("model_full", OUT_FULL, exp_full);
    check("model_busy", TX_BUSY, exp_busy);
  endtask

  initial begin
    int w;
    int thresh;
    logic rn;
    logic we;

    // Waveform checkpoints for 0x55 written at offset 0 into an idle block.
    tbl[0]  = '{1,  1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{8,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{9,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{13, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{17, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{21, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{25, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{29, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{33, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{36, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{37, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{40, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{41, 1'b1, 1'b0, 1'b0};

    // Reset held for three edges
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    check("reset_txd", TXD, 1'b1);
    check("reset_full", OUT_FULL, 1'b0);
    check("reset_busy", TX_BUSY, 1'b0);
    step(1'b1, 1'b0, 8'h00);

    // Single byte 0x55, table-driven checkpoints
    step(1'b1, 1'b1, 8'h55);
    for (int off = 1; off <= 41; off++) begin
      step(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 15; k++) begin
        if (tbl[k].off == off) begin
          check($sformatf("single55_txd_off%0d", off), TXD, tbl[k].txd);
          check($sformatf("single55_busy_off%0d", off), TX_BUSY, tbl[k].busy);
          check($sformatf("single55_full_off%0d", off), OUT_FULL, tbl[k].full);
        end
      end
    end

    // Back-to-back 0xA5 then 0x3C (second write after the pop when only one slot)
    w = (CAP > 1) ? 1 : 2;
    step(1'b1, 1'b1, 8'hA5);
    for (int off = 1; off <= 82; off++) begin
      step(1'b1, (off == w), 8'h3C);
      if (off == 40) check("b2b_stop_a5", TXD, 1'b1);
      if (off == 41) check("b2b_start_3c", TXD, 1'b0);
      if (off == 45) check("b2b_3c_bit0", TXD, 1'b0);
      if (off == 53) check("b2b_3c_bit2", TXD, 1'b1);
      if (off == 80) check("b2b_busy_80", TX_BUSY, 1'b1);
      if (off == 81) check("b2b_busy_81", TX_BUSY, 1'b0);
    end

`ifdef CORE_OUT_FIFO_EN
    // Overflow: 18 consecutive writes 0x00..0x11
    for (int i = 0; i <= 17; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (i == 15) check("ovf_full_15", OUT_FULL, 1'b0);
      if (i == 16) check("ovf_full_16", OUT_FULL, 1'b1);
      if (i == 17) check("ovf_full_17", OUT_FULL, 1'b1);
    end
    for (int off = 18; off <= 682; off++) begin
      step(1'b1, 1'b0, 8'h00);
      if (off == 18)  check("ovf_full_after_drop", OUT_FULL, 1'b1);
      if (off == 680) check("ovf_busy_680", TX_BUSY, 1'b1);
      if (off == 681) check("ovf_busy_681", TX_BUSY, 1'b0);
    end
`else
    // Holding register: 0x11, gap, 0x22 held, 0x33 dropped
    step(1'b1, 1'b1, 8'h11);
    check("hold_full_0", OUT_FULL, 1'b1);
    step(1'b1, 1'b0, 8'h00);
    check("hold_full_1", OUT_FULL, 1'b0);
    step(1'b1, 1'b1, 8'h22);
    check("hold_full_2", OUT_FULL, 1'b1);
    step(1'b1, 1'b1, 8'h33);
    check("hold_full_3", OUT_FULL, 1'b1);
    for (int off = 4; off <= 82; off++) begin
      step(1'b1, 1'b0, 8'h00);
      if (off == 41) check("hold_22_start", TXD, 1'b0);
      if (off == 45) check("hold_22_bit0", TXD, 1'b0);
      if (off == 49) check("hold_22_bit1", TXD, 1'b1);
      if (off == 80) check("hold_busy_80", TX_BUSY, 1'b1);
      if (off == 81) check("hold_busy_81", TX_BUSY, 1'b0);
    end
`endif

    // Reset during data bit 3 of 0xF0
    step(1'b1, 1'b1, 8'hF0);
    for (int off = 1; off <= 17; off++) step(1'b1, 1'b0, 8'h00);
    check("midrst_bit3_before", TXD, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("midrst_txd", TXD, 1'b1);
    check("midrst_busy", TX_BUSY, 1'b0);
    check("midrst_full", OUT_FULL, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h81);
    for (int off = 1; off <= 42; off++) begin
      step(1'b1, 1'b0, 8'h00);
      if (off == 1)  check("post_rst_start", TXD, 1'b0);
      if (off == 5)  check("post_rst_bit0", TXD, 1'b1);
      if (off == 9)  check("post_rst_bit1", TXD, 1'b0);
      if (off == 33) check("post_rst_bit7", TXD, 1'b1);
      if (off == 41) check("post_rst_idle", TX_BUSY, 1'b0);
    end

    // Randomized traffic with varying write density and rare resets
    thresh = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) thresh = $urandom_range(1, 15);
      rn = ($urandom_range(0, 999) != 0);
      we = ($urandom_range(0, 15) < thresh);
      step(rn, we, 8'($urandom));
    end
    for (int c = 0; c < 800; c++) step(1'b1, 1'b0, 8'h00);
    check("final_idle_busy", TX_BUSY, 1'b0);
    check("final_idle_txd", TXD, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
